// File: rtl/rgmii_link_ctrl_pkg.sv
// Shared definitions for the RGMII link/speed controller: speed codes,
// controller state encoding and in-band status nibble field positions.
package rgmii_link_ctrl_pkg;

    // Speed select codes driven to the RGMII PHY interface
    localparam logic [1:0] SPEED_10M     = 2'b00;
    localparam logic [1:0] SPEED_100M    = 2'b01;
    localparam logic [1:0] SPEED_1000M   = 2'b10;
    localparam logic [1:0] SPEED_INVALID = 2'b11;

    // In-band status nibble layout
    localparam int STAT_LINK_BIT   = 0;
    localparam int STAT_SPEED_LSB  = 1;
    localparam int STAT_DUPLEX_BIT = 3;

    // Link controller states
    typedef enum logic [2:0] {
        ST_LINK_DOWN = 3'd0,
        ST_LINK_UP   = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_SWITCH    = 3'd3,
        ST_SETTLE    = 3'd4
    } link_state_e;

    // Extract the 2-bit speed field from a status nibble
    function automatic logic [1:0] nib_speed(input logic [3:0] nib);
        return nib[STAT_SPEED_LSB +: 2];
    endfunction

endpackage

// File: rtl/rgmii_status_filter.sv
// Debouncer for RGMII in-band status samples. Tracks a candidate nibble and
// how many consecutive valid samples matched it; raises commit when the
// candidate becomes stable, or is stable but differs from what the controller
// last acted on. Samples carrying the reserved speed code are flagged and
// never reach the candidate logic. srst clears the candidate synchronously.
module rgmii_status_filter
    import rgmii_link_ctrl_pkg::*;
#(
    parameter int STABLE_COUNT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       srst,
    input  logic       sample_valid,
    input  logic [3:0] sample,
    input  logic [3:0] committed,
    output logic       commit,
    output logic [3:0] commit_nib,
    output logic       invalid
);

    localparam logic [7:0] STABLE_L = 8'(STABLE_COUNT);

    logic [3:0] cand_r;
    logic [7:0] cnt_r;
    logic       invalid_s;
    logic       good_s;
    logic       match_s;
    logic       sat_s;
    logic [7:0] cnt_nxt_s;
    logic       commit_s;

    // Classify the sample, compute the next match count and the commit strobe
    always_comb begin
        invalid_s = sample_valid && (nib_speed(sample) == SPEED_INVALID);
        good_s    = sample_valid && !invalid_s;
        match_s   = (cnt_r != 8'd0) && (sample == cand_r);
        sat_s     = match_s && (cnt_r == STABLE_L);
        if (sat_s) begin
            cnt_nxt_s = cnt_r;
        end else if (match_s) begin
            cnt_nxt_s = cnt_r + 8'd1;
        end else begin
            cnt_nxt_s = 8'd1;
        end
        if (good_s && !srst && (cnt_nxt_s == STABLE_L)) begin
            commit_s = !sat_s || (sample != committed);
        end else begin
            commit_s = 1'b0;
        end
    end

    // Candidate and consecutive-match counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_r <= 4'd0;
            cnt_r  <= 8'd0;
        end else if (srst) begin
            cand_r <= 4'd0;
            cnt_r  <= 8'd0;
        end else if (good_s) begin
            cand_r <= sample;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign commit     = commit_s;
    assign commit_nib = sample;
    assign invalid    = invalid_s;

endmodule

// File: rtl/rgmii_link_ctrl.sv
// RGMII link/speed controller. Debounces in-band status, tracks link and
// duplex, and sequences speed changes: hold TX, let the current frame drain,
// switch the speed select, settle, then release TX with a speed_change pulse.
// A link that stops reporting status for LINK_TIMEOUT cycles is dropped.
// Optional build macro RGMII_LINK_CTRL_FORCE_EN adds force_en/force_speed to
// override the filter and timeout with a fixed full-duplex link.
module rgmii_link_ctrl
    import rgmii_link_ctrl_pkg::*;
#(
    parameter int         STABLE_COUNT  = 8,
    parameter int         SETTLE_CYCLES = 64,
    parameter int         LINK_TIMEOUT  = 1000000,
    parameter logic [1:0] DEFAULT_SPEED = 2'b10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       status_valid,
    input  logic [3:0] status_nibble,
    input  logic       tx_busy,
`ifdef RGMII_LINK_CTRL_FORCE_EN
    input  logic       force_en,
    input  logic [1:0] force_speed,
`endif
    output logic [1:0] speed,
    output logic       link_up,
    output logic       full_duplex,
    output logic       tx_hold,
    output logic       speed_change,
    output logic       status_err
);

    localparam logic [15:0] SETTLE_L = 16'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TO_LIM   = 32'(LINK_TIMEOUT - 1);

    link_state_e state_r, state_n;
    logic [1:0]  speed_r, speed_n;
    logic        link_up_r, link_up_n;
    logic        full_duplex_r, full_duplex_n;
    logic        tx_hold_r, tx_hold_n;
    logic        speed_change_r, speed_change_n;
    logic        status_err_r;
    logic [15:0] settle_cnt_r, settle_cnt_n;
    logic [3:0]  tgt_r;
    logic [31:0] to_cnt_r;

    logic        filt_commit_s;
    logic [3:0]  filt_nib_s;
    logic        filt_inv_s;
    logic        filt_srst_s;
    logic        eff_commit_s;
    logic [3:0]  eff_nib_s;
    logic        force_active_s;
    logic        force_bad_s;
    logic        timeout_s;
    logic        c_link_s;
    logic [1:0]  c_speed_s;
    logic        c_dup_s;
    logic [3:0]  sel_nib_s;

    rgmii_status_filter #(
        .STABLE_COUNT (STABLE_COUNT)
    ) u_filter (
        .clk          (clk),
        .rst_n        (rst_n),
        .srst         (filt_srst_s),
        .sample_valid (status_valid),
        .sample       (status_nibble),
        .committed    (tgt_r),
        .commit       (filt_commit_s),
        .commit_nib   (filt_nib_s),
        .invalid      (filt_inv_s)
    );

`ifdef RGMII_LINK_CTRL_FORCE_EN
    logic [3:0] force_nib_s;

    // Forced mode replaces the filter commit with a fixed full-duplex link
    always_comb begin
        force_nib_s    = {1'b1, force_speed, 1'b1};
        force_active_s = force_en;
        force_bad_s    = force_en && (force_speed == SPEED_INVALID);
        if (force_en) begin
            eff_commit_s = !force_bad_s && (force_nib_s != tgt_r);
            eff_nib_s    = force_nib_s;
        end else begin
            eff_commit_s = filt_commit_s;
            eff_nib_s    = filt_nib_s;
        end
    end
`else
    // Filter commit drives the controller directly
    always_comb begin
        force_active_s = 1'b0;
        force_bad_s    = 1'b0;
        eff_commit_s   = filt_commit_s;
        eff_nib_s      = filt_nib_s;
    end
`endif

    // Timeout fires on the LINK_TIMEOUT-th consecutive cycle without status
    always_comb begin
        if ((LINK_TIMEOUT != 0) && (state_r != ST_LINK_DOWN) &&
            !force_active_s && !status_valid) begin
            timeout_s = (to_cnt_r == TO_LIM);
        end else begin
            timeout_s = 1'b0;
        end
        filt_srst_s = timeout_s || force_active_s;
    end

    // Cycles since the last status sample while a link is being tracked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= 32'd0;
        end else if ((state_r != ST_LINK_DOWN) && !status_valid &&
                     !force_active_s && !timeout_s) begin
            to_cnt_r <= to_cnt_r + 32'd1;
        end else begin
            to_cnt_r <= 32'd0;
        end
    end

    // Last committed status nibble; SWITCH takes its target speed from here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_r <= 4'd0;
        end else if (timeout_s) begin
            tgt_r <= 4'd0;
        end else if (eff_commit_s) begin
            tgt_r <= eff_nib_s;
        end
    end

    // Controller next-state and registered-output decode
    always_comb begin
        state_n        = state_r;
        speed_n        = speed_r;
        link_up_n      = link_up_r;
        full_duplex_n  = full_duplex_r;
        tx_hold_n      = tx_hold_r;
        speed_change_n = 1'b0;
        settle_cnt_n   = settle_cnt_r;
        c_link_s       = eff_nib_s[STAT_LINK_BIT];
        c_speed_s      = nib_speed(eff_nib_s);
        c_dup_s        = eff_nib_s[STAT_DUPLEX_BIT];
        sel_nib_s      = eff_commit_s ? eff_nib_s : tgt_r;

        if (timeout_s) begin
            state_n   = ST_LINK_DOWN;
            link_up_n = 1'b0;
            tx_hold_n = 1'b1;
        end else begin
            case (state_r)
                ST_LINK_DOWN: begin
                    link_up_n = 1'b0;
                    tx_hold_n = 1'b1;
                    if (eff_commit_s && c_link_s) begin
                        if (c_speed_s != speed_r) begin
                            state_n = ST_DRAIN;
                        end else begin
                            state_n       = ST_LINK_UP;
                            link_up_n     = 1'b1;
                            full_duplex_n = c_dup_s;
                            tx_hold_n     = 1'b0;
                        end
                    end else begin
                        state_n = ST_LINK_DOWN;
                    end
                end
                ST_LINK_UP: begin
                    if (eff_commit_s && !c_link_s) begin
                        state_n   = ST_LINK_DOWN;
                        link_up_n = 1'b0;
                        tx_hold_n = 1'b1;
                    end else if (eff_commit_s && (c_speed_s != speed_r)) begin
                        state_n   = ST_DRAIN;
                        link_up_n = 1'b0;
                        tx_hold_n = 1'b1;
                    end else if (eff_commit_s) begin
                        full_duplex_n = c_dup_s;
                    end else begin
                        state_n = ST_LINK_UP;
                    end
                end
                ST_DRAIN: begin
                    link_up_n = 1'b0;
                    tx_hold_n = 1'b1;
                    if (eff_commit_s && !c_link_s) begin
                        state_n = ST_LINK_DOWN;
                    end else if (!tx_busy) begin
                        state_n = ST_SWITCH;
                    end else begin
                        state_n = ST_DRAIN;
                    end
                end
                ST_SWITCH: begin
                    link_up_n = 1'b0;
                    tx_hold_n = 1'b1;
                    if (!sel_nib_s[STAT_LINK_BIT]) begin
                        state_n = ST_LINK_DOWN;
                    end else begin
                        state_n       = ST_SETTLE;
                        speed_n       = nib_speed(sel_nib_s);
                        full_duplex_n = sel_nib_s[STAT_DUPLEX_BIT];
                        settle_cnt_n  = SETTLE_L;
                    end
                end
                ST_SETTLE: begin
                    link_up_n = 1'b0;
                    tx_hold_n = 1'b1;
                    if (eff_commit_s && !c_link_s) begin
                        state_n = ST_LINK_DOWN;
                    end else if (eff_commit_s && (c_speed_s != speed_r)) begin
                        state_n = ST_DRAIN;
                    end else begin
                        if (eff_commit_s) begin
                            full_duplex_n = c_dup_s;
                        end else begin
                            full_duplex_n = full_duplex_r;
                        end
                        if (settle_cnt_r == 16'd0) begin
                            state_n        = ST_LINK_UP;
                            link_up_n      = 1'b1;
                            tx_hold_n      = 1'b0;
                            speed_change_n = 1'b1;
                        end else begin
                            settle_cnt_n = settle_cnt_r - 16'd1;
                        end
                    end
                end
                default: begin
                    state_n   = ST_LINK_DOWN;
                    link_up_n = 1'b0;
                    tx_hold_n = 1'b1;
                end
            endcase
        end
    end

    // Controller state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_LINK_DOWN;
            speed_r        <= DEFAULT_SPEED;
            link_up_r      <= 1'b0;
            full_duplex_r  <= 1'b0;
            tx_hold_r      <= 1'b1;
            speed_change_r <= 1'b0;
            settle_cnt_r   <= 16'd0;
        end else begin
            state_r        <= state_n;
            speed_r        <= speed_n;
            link_up_r      <= link_up_n;
            full_duplex_r  <= full_duplex_n;
            tx_hold_r      <= tx_hold_n;
            speed_change_r <= speed_change_n;
            settle_cnt_r   <= settle_cnt_n;
        end
    end

    // One-cycle error pulse for a reserved speed code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_err_r <= 1'b0;
        end else begin
            status_err_r <= filt_inv_s || force_bad_s;
        end
    end

    assign speed        = speed_r;
    assign link_up      = link_up_r;
    assign full_duplex  = full_duplex_r;
    assign tx_hold      = tx_hold_r;
    assign speed_change = speed_change_r;
    assign status_err   = status_err_r;

endmodule

// File: doc/rgmii_link_ctrl.md
Name: rgmii_link_ctrl

Overview:
- Link/speed controller for the RGMII PHY interface.
- Decodes RGMII in-band link status nibbles, already qualified by the MAC RX path and synchronised into clk, and debounces them.
- Sequences safe speed changes: holds off MAC TX, waits for the in-flight frame to finish, switches the 2-bit speed select feeding the RGMII PHY interface, then waits a settle time before releasing TX.
- Drives link_up/duplex status to the MAC and CSR block.

Parameters:
- STABLE_COUNT, 8: consecutive identical status samples required before commit (1..255).
- SETTLE_CYCLES, 64: clk cycles held in SETTLE after a speed switch (1..65535).
- LINK_TIMEOUT, 1000000: clk cycles without status_valid before forcing link down (0 disables).
- DEFAULT_SPEED, 2'b10: speed output after reset (00=10M, 01=100M, 10=1000M).

Ports:
- clk  in  1  single clock, the TX-side clock of the PHY interface.
- rst_n  in  1  asynchronous, active-low reset.
- status_valid  in  1  one in-band status sample present this cycle (RX idle, dv=0, er=0).
- status_nibble  in  4  bit0 link, bits2:1 speed, bit3 full-duplex.
- tx_busy  in  1  MAC TX frame in progress (gmii tx_en).
- speed  out  2  speed select to the RGMII PHY interface.
- link_up  out  1  committed link state.
- full_duplex  out  1  committed duplex.
- tx_hold  out  1  MAC must not start a new frame while high.
- speed_change  out  1  one-cycle pulse when a new speed becomes active and TX is released.
- status_err  out  1  one-cycle pulse on a sample with speed code 2'b11.

Behaviour:
- Reset values: speed=DEFAULT_SPEED, link_up=0, full_duplex=0, tx_hold=1, speed_change=0, status_err=0, state=LINK_DOWN, filter counters=0.
- Sample with speed code 11: discarded, not fed to the filter; status_err pulses the next cycle.
- Filter:
  - A valid sample equal to cand increments cnt, saturating at STABLE_COUNT.
  - A different sample sets cand=sample and cnt=1.
  - "commit" is asserted in the cycle cnt reaches STABLE_COUNT, and again for any later matching sample while cand differs from the committed fields.
- States: LINK_DOWN, LINK_UP, DRAIN, SWITCH, SETTLE.
- LINK_DOWN: tx_hold=1. On commit with link=1:
  - speed differs from current -> DRAIN.
  - speed equal -> LINK_UP with link_up=1, full_duplex=cand[3], tx_hold=0 the next cycle.
- LINK_UP: tx_hold=0.
  - Commit with link=0 -> LINK_DOWN; link_up=0 and tx_hold=1 the next cycle; speed unchanged.
  - Commit with new speed -> DRAIN.
  - Commit with duplex change only -> update full_duplex, stay in LINK_UP.
- DRAIN: tx_hold=1, link_up=0. Leaves for SWITCH in the first cycle tx_busy=0. Latency is 1 cycle minimum; the frame is never truncated.
- SWITCH: one cycle; speed<=cand speed, full_duplex<=cand[3]; counter loaded with SETTLE_CYCLES-1.
- SETTLE: tx_hold=1. Counter decrements to 0, then -> LINK_UP; link_up=1, tx_hold=0 and speed_change=1 all appear in the same cycle.
- Commits during DRAIN/SETTLE:
  - link=0 -> LINK_DOWN immediately.
  - Another new speed -> DRAIN (from SETTLE) or retarget (in DRAIN).
- Timeout: in any state other than LINK_DOWN, LINK_TIMEOUT cycles without status_valid -> LINK_DOWN and the filter clears. The timeout counter resets on every status_valid.
- Simultaneous events:
  - Timeout and commit in the same cycle: timeout wins.
  - A commit in the same cycle as the DRAIN->SWITCH transition: SWITCH uses the newest cand.
- Reset asserted mid-operation returns all outputs to reset values asynchronously.

Optional Feature:
- Macro RGMII_LINK_CTRL_FORCE_EN.
- With it: adds inputs force_en (1) and force_speed (2).
  - force_en=1 bypasses the filter and timeout; commit is {link=1, force_speed, duplex=1}, applied through the same DRAIN/SWITCH/SETTLE sequence.
  - Dropping force_en returns control to the filter, which restarts with cnt=0.
  - force_speed=11 is ignored and pulses status_err.
- Without it: ports absent; behaviour as above.

Decomposition:
- Package rgmii_link_ctrl_pkg holds:
  - speed constants SPEED_10M/100M/1000M;
  - the state encoding;
  - status nibble bit positions (STAT_LINK_BIT, STAT_SPEED_LSB, STAT_DUPLEX_BIT).
- One sub-module: rgmii_status_filter (cand/cnt debouncer, invalid-code check, commit output).

Test Plan:
- Reset, then 8 samples 4'b1101 (link, 1000M, FD) with DEFAULT_SPEED=10 -> link_up=1, full_duplex=1, speed=10, tx_hold=0 one cycle after the 8th sample; no speed_change.
- Link up at 1000M, then 8 samples 4'b1011 (100M) with tx_busy=1 for 20 more cycles -> tx_hold=1 within 1 cycle; speed stays 10 until tx_busy falls; speed=01 the cycle after SWITCH; speed_change pulse exactly SETTLE_CYCLES cycles later.
- Alternating samples 4'b1101/4'b1011 for 100 samples -> no commit; speed, link_up and tx_hold unchanged.
- 8 samples 4'b0000 during SETTLE -> LINK_DOWN next cycle; link_up=0, no speed_change pulse, speed keeps the new value.
- Sample 4'b0111 -> status_err pulse one cycle later; filter cnt unaffected.
- LINK_TIMEOUT=100, link up, then no status_valid for 100 cycles -> link_up=0, tx_hold=1 at cycle 100; rst_n low mid-SETTLE -> outputs return to reset values immediately.
